// File: rtl/ctrl_pipe_hazard.sv
// Control bus pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall
// and MEM-stage branch resolution that squashes younger instructions.
module ctrl_pipe_hazard #(
    parameter int REG_ADDR_W = 5,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            id_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_zero,
    output logic                  ex_RegDst,
    output logic                  ex_ALUSrc,
    output logic [1:0]            ex_ALUOp,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  mem_Branch,
    output logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic                  wb_RegWrite,
    output logic                  wb_MemtoReg,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic                  branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush
);

    localparam int C_REGDST   = 8;
    localparam int C_ALUSRC   = 7;
    localparam int C_MEMTOREG = 6;
    localparam int C_REGWRITE = 5;
    localparam int C_MEMREAD  = 4;
    localparam int C_MEMWRITE = 3;
    localparam int C_BRANCH   = 2;

    logic [8:0]            ex_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_MemtoReg;
    logic                  mem_RegWrite;
    logic                  mem_zero;
    logic                  stall;
    logic [REG_ADDR_W-1:0] ex_dst;

    always_comb begin
        stall = HAZARD_EN
              && ex_ctrl[C_MEMREAD]
              && (ex_rt != '0)
              && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

    assign ex_RegDst    = ex_ctrl[C_REGDST];
    assign ex_ALUSrc    = ex_ctrl[C_ALUSRC];
    assign ex_ALUOp     = ex_ctrl[1:0];
    assign ex_dst       = ex_ctrl[C_REGDST] ? ex_rd : ex_rt;
    assign branch_taken = mem_Branch & mem_zero;
    // A taken branch squashes the stalling instruction, so it must not hold PC
    assign pc_write     = ~stall | branch_taken;
    assign ifid_write   = ~stall | branch_taken;
    assign ifid_flush   = branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl       <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            mem_MemtoReg  <= 1'b0;
            mem_RegWrite  <= 1'b0;
            mem_MemRead   <= 1'b0;
            mem_MemWrite  <= 1'b0;
            mem_Branch    <= 1'b0;
            mem_write_reg <= '0;
            mem_zero      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemtoReg   <= 1'b0;
            wb_write_reg  <= '0;
        end else begin
            ex_rt <= id_rt;
            ex_rd <= id_rd;
            if (stall || branch_taken) ex_ctrl <= '0;
            else                       ex_ctrl <= id_ctrl;

            mem_write_reg <= ex_dst;
            mem_zero      <= ex_zero;
            if (branch_taken) begin
                mem_MemtoReg <= 1'b0;
                mem_RegWrite <= 1'b0;
                mem_MemRead  <= 1'b0;
                mem_MemWrite <= 1'b0;
                mem_Branch   <= 1'b0;
            end else begin
                mem_MemtoReg <= ex_ctrl[C_MEMTOREG];
                mem_RegWrite <= ex_ctrl[C_REGWRITE];
                mem_MemRead  <= ex_ctrl[C_MEMREAD];
                mem_MemWrite <= ex_ctrl[C_MEMWRITE];
                mem_Branch   <= ex_ctrl[C_BRANCH];
            end

            wb_RegWrite  <= mem_RegWrite;
            wb_MemtoReg  <= mem_MemtoReg;
            wb_write_reg <= mem_write_reg;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: expected values queued with a
// due cycle at drive time and checked when that cycle arrives.
module tb_ctrl_pipe_hazard;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] id_ctrl;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;

    logic       ex_RegDst, ex_ALUSrc;
    logic [1:0] ex_ALUOp;
    logic [4:0] ex_rt;
    logic       mem_MemRead, mem_MemWrite, mem_Branch;
    logic [4:0] mem_write_reg;
    logic       wb_RegWrite, wb_MemtoReg;
    logic [4:0] wb_write_reg;
    logic       branch_taken, pc_write, ifid_write, ifid_flush;

    logic       n_ex_RegDst, n_ex_ALUSrc;
    logic [1:0] n_ex_ALUOp;
    logic [4:0] n_ex_rt;
    logic       n_mem_MemRead, n_mem_MemWrite, n_mem_Branch;
    logic [4:0] n_mem_write_reg;
    logic       n_wb_RegWrite, n_wb_MemtoReg;
    logic [4:0] n_wb_write_reg;
    logic       n_branch_taken, n_pc_write, n_ifid_write, n_ifid_flush;

    localparam logic [8:0] RTYPE = 9'b100100010;
    localparam logic [8:0] LW    = 9'b011110000;
    localparam logic [8:0] BEQ   = 9'b000000101;

    localparam int S_EXRD = 0, S_EXSRC = 1, S_EXOP = 2, S_EXRT = 3;
    localparam int S_MRD = 4, S_MWR = 5, S_MBR = 6, S_MWREG = 7;
    localparam int S_WRW = 8, S_WMTR = 9, S_WWREG = 10, S_BT = 11;
    localparam int S_PCW = 12, S_IFW = 13, S_IFF = 14;

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] exp;
        string      tag;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    ctrl_pipe_hazard #(.REG_ADDR_W(5), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .ex_rt(ex_rt), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_Branch(mem_Branch), .mem_write_reg(mem_write_reg),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_write_reg(wb_write_reg), .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush)
    );

    ctrl_pipe_hazard #(.REG_ADDR_W(5), .HAZARD_EN(1'b0)) dut_nohz (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_RegDst(n_ex_RegDst), .ex_ALUSrc(n_ex_ALUSrc), .ex_ALUOp(n_ex_ALUOp),
        .ex_rt(n_ex_rt), .mem_MemRead(n_mem_MemRead),
        .mem_MemWrite(n_mem_MemWrite), .mem_Branch(n_mem_Branch),
        .mem_write_reg(n_mem_write_reg), .wb_RegWrite(n_wb_RegWrite),
        .wb_MemtoReg(n_wb_MemtoReg), .wb_write_reg(n_wb_write_reg),
        .branch_taken(n_branch_taken), .pc_write(n_pc_write),
        .ifid_write(n_ifid_write), .ifid_flush(n_ifid_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            S_EXRD:  return {7'd0, ex_RegDst};
            S_EXSRC: return {7'd0, ex_ALUSrc};
            S_EXOP:  return {6'd0, ex_ALUOp};
            S_EXRT:  return {3'd0, ex_rt};
            S_MRD:   return {7'd0, mem_MemRead};
            S_MWR:   return {7'd0, mem_MemWrite};
            S_MBR:   return {7'd0, mem_Branch};
            S_MWREG: return {3'd0, mem_write_reg};
            S_WRW:   return {7'd0, wb_RegWrite};
            S_WMTR:  return {7'd0, wb_MemtoReg};
            S_WWREG: return {3'd0, wb_write_reg};
            S_BT:    return {7'd0, branch_taken};
            S_PCW:   return {7'd0, pc_write};
            S_IFW:   return {7'd0, ifid_write};
            S_IFF:   return {7'd0, ifid_flush};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] o,
                       input logic [7:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic now(input string tag, input int sel, input logic [7:0] e);
        chk(tag, obs(sel), e);
    endtask

    task automatic push(input int off, input int sel, input logic [7:0] e,
                        input string tag);
        sb_t s;
        s.due = cyc + off;
        s.sel = sel;
        s.exp = e;
        s.tag = tag;
        sb.push_back(s);
    endtask

    task automatic check_due();
        int i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_due();
    endtask

    task automatic drive(input logic [8:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        id_ctrl = c;
        id_rs   = rs;
        id_rt   = rt;
        id_rd   = rd;
        #1;
    endtask

    task automatic idle(input int n);
        drive(9'd0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic all_reset(input string tag);
        for (int s = S_EXRD; s <= S_WWREG; s++) now(tag, s, 8'd0);
        now({tag, "_bt"}, S_BT, 8'd0);
        now({tag, "_pcw"}, S_PCW, 8'd1);
        now({tag, "_ifw"}, S_IFW, 8'd1);
        now({tag, "_iff"}, S_IFF, 8'd0);
    endtask

    initial begin
        reset   = 1'b1;
        ex_zero = 1'b0;
        drive(RTYPE, 5'd3, 5'd4, 5'd5);
        tick();
        tick();
        all_reset("rst");
        reset = 1'b0;
        idle(1);

        // R-type latency through all stages
        drive(RTYPE, 5'd1, 5'd3, 5'd7);
        push(1, S_EXRD, 8'd1, "r_exrd");
        push(1, S_EXOP, 8'd2, "r_exop");
        push(1, S_EXSRC, 8'd0, "r_exsrc");
        push(1, S_EXRT, 8'd3, "r_exrt");
        push(2, S_MWREG, 8'd7, "r_mwreg");
        push(3, S_WRW, 8'd1, "r_wrw");
        push(3, S_WMTR, 8'd0, "r_wmtr");
        push(3, S_WWREG, 8'd7, "r_wwreg");
        tick();
        idle(4);

        // lw rt=8 then add rs=8: one-cycle stall
        drive(LW, 5'd2, 5'd8, 5'd0);
        tick();
        drive(RTYPE, 5'd8, 5'd9, 5'd10);
        now("lu_pcw", S_PCW, 8'd0);
        now("lu_ifw", S_IFW, 8'd0);
        now("lu_iff", S_IFF, 8'd0);
        chk("nohz_pcw", {7'd0, n_pc_write}, 8'd1);
        chk("nohz_ifw", {7'd0, n_ifid_write}, 8'd1);
        push(1, S_EXRD, 8'd0, "lu_bub_rd");
        push(1, S_EXOP, 8'd0, "lu_bub_op");
        push(1, S_EXSRC, 8'd0, "lu_bub_src");
        push(1, S_MRD, 8'd1, "lu_mrd");
        push(1, S_MWREG, 8'd8, "lu_mwreg");
        tick();
        now("lu_rel_pcw", S_PCW, 8'd1);
        now("lu_rel_ifw", S_IFW, 8'd1);
        push(1, S_EXRD, 8'd1, "add_exrd");
        push(1, S_EXOP, 8'd2, "add_exop");
        push(1, S_EXRT, 8'd9, "add_exrt");
        push(1, S_WRW, 8'd1, "lw_wrw");
        push(1, S_WMTR, 8'd1, "lw_wmtr");
        push(1, S_WWREG, 8'd8, "lw_wwreg");
        push(2, S_MWREG, 8'd10, "add_mwreg");
        tick();
        idle(4);

        // lw rt=0 never stalls; rt-side match does
        drive(LW, 5'd0, 5'd0, 5'd0);
        tick();
        drive(RTYPE, 5'd0, 5'd0, 5'd4);
        now("lw0_pcw", S_PCW, 8'd1);
        now("lw0_ifw", S_IFW, 8'd1);
        tick();
        drive(LW, 5'd1, 5'd6, 5'd0);
        tick();
        drive(RTYPE, 5'd2, 5'd6, 5'd4);
        now("lurt_pcw", S_PCW, 8'd0);
        tick();
        idle(4);

        // taken beq squashes younger instructions
        drive(BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b1;
        drive(RTYPE, 5'd3, 5'd4, 5'd5);
        push(1, S_BT, 8'd1, "bq_bt");
        push(1, S_IFF, 8'd1, "bq_iff");
        push(1, S_MBR, 8'd1, "bq_mbr");
        tick();
        ex_zero = 1'b0;
        drive(RTYPE, 5'd3, 5'd4, 5'd6);
        now("bq_pcw", S_PCW, 8'd1);
        push(1, S_EXRD, 8'd0, "bq_fl_exrd");
        push(1, S_EXOP, 8'd0, "bq_fl_exop");
        push(1, S_MBR, 8'd0, "bq_fl_mbr");
        push(1, S_BT, 8'd0, "bq_fl_bt");
        push(1, S_WRW, 8'd0, "bq_wb_own");
        push(2, S_WRW, 8'd0, "bq_fl_wrw");
        tick();
        idle(4);

        // untaken beq
        drive(BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b0;
        drive(9'd0, 5'd0, 5'd0, 5'd0);
        push(1, S_MBR, 8'd1, "bn_mbr");
        push(1, S_BT, 8'd0, "bn_bt");
        push(1, S_IFF, 8'd0, "bn_iff");
        tick();
        idle(3);

        // branch and load-use in the same cycle
        drive(BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b1;
        drive(LW, 5'd3, 5'd8, 5'd0);
        tick();
        ex_zero = 1'b0;
        drive(RTYPE, 5'd8, 5'd9, 5'd10);
        now("pr_bt", S_BT, 8'd1);
        now("pr_pcw", S_PCW, 8'd1);
        now("pr_ifw", S_IFW, 8'd1);
        now("pr_iff", S_IFF, 8'd1);
        push(1, S_EXRD, 8'd0, "pr_exrd");
        push(1, S_MRD, 8'd0, "pr_mrd");
        tick();
        idle(4);

        // reset while stalled
        drive(LW, 5'd2, 5'd8, 5'd0);
        tick();
        drive(RTYPE, 5'd8, 5'd9, 5'd10);
        now("rs_pre_pcw", S_PCW, 8'd0);
        reset = 1'b1;
        tick();
        all_reset("rs_mid");
        reset = 1'b0;
        idle(1);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
